// File: rtl/uart_io_pkg.sv
// Shared types and helpers for the UART in/out sequencer.
package uart_io_pkg;

  typedef enum logic [1:0] {IDLE, START, ACCEPT, DRAIN} tx_state_t;

  localparam int STAT_CNT_W = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_io_ctrl_if.sv
// CPU-side in/out instruction handshake; master is the control FSM, slave is uart_io_ctrl.
interface uart_io_ctrl_if;
  logic        out_req;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        in_req;
  logic        in_valid;
  logic [31:0] in_data;

  modport master (output out_req, out_data, in_req, input out_ready, in_valid, in_data);
  modport slave  (input out_req, out_data, in_req, output out_ready, in_valid, in_data);
endinterface

// File: rtl/io_byte_fifo.sv
// Show-ahead byte FIFO: head is combinational, a push at N is visible at N+1.
// A push while full is dropped unless a pop in the same cycle frees the slot.
module io_byte_fifo
  import uart_io_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int PW = ptr_w(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_io_ctrl.sv
// Buffers CPU out bytes into uart_tx one frame at a time and queues uart_rx bytes for in-instructions.
// Optional receive statistics (overflow, framing error, drop count) when UART_IO_STAT_EN is defined.
module uart_io_ctrl
  import uart_io_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  uart_io_ctrl_if.slave cpu,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       rx_ferr,
  output logic       tx_idle
`ifdef UART_IO_STAT_EN
  ,
  input  logic                  stat_clr,
  output logic                  stat_rx_ovf,
  output logic                  stat_rx_ferr,
  output logic [STAT_CNT_W-1:0] stat_drop_cnt
`endif
);
  tx_state_t  state;
  tx_state_t  state_nxt;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_pop;
  logic       tx_load;
  logic [7:0] tx_head;
  logic       rx_full;
  logic       rx_empty;
  logic       rx_push;
  logic       rx_pop;
  logic [7:0] rx_head;

  // out_ready uses the pre-pop count, so a push onto a full FIFO waits a cycle.
  assign cpu.out_ready = !tx_full;

  io_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu.out_req && !tx_full),
    .pop   (tx_pop),
    .din   (cpu.out_data),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_data <= 8'h00;
    end else begin
      state <= state_nxt;
      // Capture on entry so tx_data is already stable while tx_start is high.
      if (tx_load) tx_data <= tx_head;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    tx_load   = 1'b0;
    unique case (state)
      IDLE:    if (!tx_empty) begin
                 state_nxt = START;
                 tx_load   = 1'b1;
               end
      START:   begin
                 tx_pop    = 1'b1;
                 state_nxt = ACCEPT;
               end
      ACCEPT:  if (tx_busy)  state_nxt = DRAIN;
      DRAIN:   if (!tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_start = (state == START);
  assign tx_idle  = tx_empty && (state == IDLE);

  assign rx_pop  = cpu.in_req && !rx_empty;
  assign rx_push = rx_ready && !rx_ferr && (!rx_full || rx_pop);

  io_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head)
  );

  assign cpu.in_valid = !rx_empty;
  assign cpu.in_data  = rx_empty ? 32'h0 : {24'h0, rx_head};

`ifdef UART_IO_STAT_EN
  logic rx_ovf_drop;
  logic rx_ferr_drop;

  assign rx_ferr_drop = rx_ready && rx_ferr;
  assign rx_ovf_drop  = rx_ready && !rx_ferr && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_rx_ovf   <= 1'b0;
      stat_rx_ferr  <= 1'b0;
      stat_drop_cnt <= '0;
    end else begin
      if (rx_ovf_drop)  stat_rx_ovf  <= 1'b1;
      if (rx_ferr_drop) stat_rx_ferr <= 1'b1;
      if ((rx_ovf_drop || rx_ferr_drop) && (stat_drop_cnt != '1))
        stat_drop_cnt <= stat_drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Scoreboard bench for uart_io_ctrl: queue-based reference model plus a counting uart_tx stand-in.
module tb_uart_io_ctrl;
  localparam int TX_DEPTH = 16;
  localparam int RX_DEPTH = 64;
  localparam int BUSY_CYC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_ferr = 1'b0;
  logic       tx_idle;
`ifdef UART_IO_STAT_EN
  logic        stat_clr = 1'b0;
  logic        stat_rx_ovf;
  logic        stat_rx_ferr;
  logic [15:0] stat_drop_cnt;
  bit          m_ovf = 0;
  bit          m_ferr = 0;
  int          m_cnt = 0;
`endif

  uart_io_ctrl_if cpu_if();

  uart_io_ctrl #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu      (cpu_if),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rx_ferr  (rx_ferr),
    .tx_idle  (tx_idle)
`ifdef UART_IO_STAT_EN
    ,
    .stat_clr      (stat_clr),
    .stat_rx_ovf   (stat_rx_ovf),
    .stat_rx_ferr  (stat_rx_ferr),
    .stat_drop_cnt (stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] last_tx = 8'h00;
  int         busy_cnt = 0;
  int         starts = 0;
  bit         hold_busy = 0;
  bit         mute_uart = 0;
  bit         armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks outputs against the model, then applies this cycle's inputs to it.
  always @(negedge clk) begin
    if (armed) begin
      int  pre;
      bit  ovf;
      bit  ferr_drop;
      chk("out_ready", cpu_if.out_ready, tx_q.size() < TX_DEPTH);
      chk("in_valid", cpu_if.in_valid, rx_q.size() != 0);
      if (rx_q.size() != 0) chk("in_data", cpu_if.in_data, {24'h0, rx_q[0]});
      if (tx_q.size() != 0) chk("tx_idle_pending", tx_idle, 1'b0);
      if (tx_start) begin
        chk("tx_start_while_busy", busy_cnt != 0, 1'b0);
        if (tx_q.size() == 0) chk("tx_start_spurious", tx_start, 1'b0);
        else chk("tx_data_start", tx_data, tx_q[0]);
      end else begin
        chk("tx_data_hold", tx_data, last_tx);
      end
`ifdef UART_IO_STAT_EN
      chk("stat_rx_ovf", stat_rx_ovf, m_ovf);
      chk("stat_rx_ferr", stat_rx_ferr, m_ferr);
      chk("stat_drop_cnt", stat_drop_cnt, m_cnt);
`endif
      ovf = 0;
      ferr_drop = 0;
      if (rst) begin
        tx_q.delete();
        rx_q.delete();
        last_tx = 8'h00;
      end else begin
        pre = tx_q.size();
        if (tx_start && tx_q.size() != 0) begin
          last_tx = tx_q.pop_front();
          starts++;
        end
        if (cpu_if.out_req && pre < TX_DEPTH) tx_q.push_back(cpu_if.out_data);
        if (cpu_if.in_req && rx_q.size() != 0) void'(rx_q.pop_front());
        ferr_drop = rx_ready && rx_ferr;
        if (rx_ready && !rx_ferr) begin
          if (rx_q.size() < RX_DEPTH) rx_q.push_back(rx_data);
          else ovf = 1;
        end
      end
`ifdef UART_IO_STAT_EN
      if (rst || stat_clr) begin
        m_ovf = 0;
        m_ferr = 0;
        m_cnt = 0;
      end else begin
        if (ovf) m_ovf = 1;
        if (ferr_drop) m_ferr = 1;
        if ((ovf || ferr_drop) && m_cnt < 65535) m_cnt++;
      end
`endif
    end
    if (!mute_uart && tx_start) busy_cnt = BUSY_CYC;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = hold_busy || (busy_cnt != 0);
  end

  task automatic push_byte(input logic [7:0] b, input int max_cyc);
    int n = 0;
    cpu_if.out_req  = 1'b1;
    cpu_if.out_data = b;
    while (!cpu_if.out_ready && n < max_cyc) begin
      tick();
      n++;
    end
    if (!cpu_if.out_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: byte %0h not accepted within %0d cycles", b, max_cyc);
    end
    tick();
    cpu_if.out_req = 1'b0;
  endtask

  task automatic rx_inject(input logic [7:0] b, input logic ferr);
    rx_ready = 1'b1;
    rx_data  = b;
    rx_ferr  = ferr;
    tick();
    rx_ready = 1'b0;
    rx_ferr  = 1'b0;
  endtask

  task automatic wait_tx_drain(input int max_cyc);
    int n = 0;
    while (!(tx_idle && !tx_busy) && n < max_cyc) begin
      tick();
      n++;
    end
    chk("tx_drain", tx_idle, 1'b1);
  endtask

  task automatic drain_rx();
    cpu_if.in_req = 1'b1;
    repeat (RX_DEPTH + 4) tick();
    cpu_if.in_req = 1'b0;
    chk("rx_drained", cpu_if.in_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         s0;
    logic [7:0] first_b;
    logic [7:0] second_b;
    logic [7:0] b;
    cpu_if.out_req  = 1'b0;
    cpu_if.out_data = 8'h00;
    cpu_if.in_req   = 1'b0;

    rst = 1'b1;
    tick();
    armed = 1;
    tick();
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_out_ready", cpu_if.out_ready, 1'b1);
    chk("rst_in_valid", cpu_if.in_valid, 1'b0);
    chk("rst_in_data", cpu_if.in_data, 32'h0);
    chk("rst_tx_idle", tx_idle, 1'b1);
    rst = 1'b0;
    tick();

    // Three back-to-back frames.
    s0 = starts;
    push_byte(8'h41, 50);
    push_byte(8'h42, 50);
    push_byte(8'h43, 50);
    wait_tx_drain(200);
    chk("t1_starts", starts - s0, 3);

    // Fill the TX FIFO while the line is held busy.
    s0 = starts;
    push_byte(8'($urandom), 50);
    hold_busy = 1;
    for (int i = 0; i < TX_DEPTH; i++) push_byte(8'($urandom), 50);
    b = 8'($urandom);
    cpu_if.out_req  = 1'b1;
    cpu_if.out_data = b;
    repeat (20) tick();
    chk("t2_full", cpu_if.out_ready, 1'b0);
    hold_busy = 0;
    push_byte(b, 100);
    wait_tx_drain(600);
    chk("t2_starts", starts - s0, TX_DEPTH + 2);

    // Good byte followed by a framing-error byte.
    rx_inject(8'h55, 1'b0);
    chk("t3_valid", cpu_if.in_valid, 1'b1);
    rx_inject(8'hAA, 1'b1);
    chk("t3_in_data", cpu_if.in_data, 32'h55);
`ifdef UART_IO_STAT_EN
    chk("t3_ferr", stat_rx_ferr, 1'b1);
    chk("t3_drop", stat_drop_cnt, 16'd1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
`endif
    cpu_if.in_req = 1'b1;
    tick();
    cpu_if.in_req = 1'b0;
    chk("t3_popped", cpu_if.in_valid, 1'b0);

    // RX overflow, then a store made possible by a same-cycle pop.
    first_b  = 8'($urandom);
    second_b = 8'($urandom);
    rx_inject(first_b, 1'b0);
    rx_inject(second_b, 1'b0);
    for (int i = 2; i < RX_DEPTH; i++) rx_inject(8'($urandom), 1'b0);
    rx_inject(8'($urandom), 1'b0);
    chk("t4_head_kept", cpu_if.in_data, {24'h0, first_b});
`ifdef UART_IO_STAT_EN
    chk("t4_ovf", stat_rx_ovf, 1'b1);
    stat_clr = 1'b1;
    rx_inject(8'($urandom), 1'b0);
    stat_clr = 1'b0;
    chk("t6_ovf_clr", stat_rx_ovf, 1'b0);
    chk("t6_cnt_clr", stat_drop_cnt, 16'd0);
`endif
    cpu_if.in_req = 1'b1;
    rx_inject(8'($urandom), 1'b0);
    cpu_if.in_req = 1'b0;
    chk("t4_head_next", cpu_if.in_data, {24'h0, second_b});
    drain_rx();

    // Mixed random traffic on both directions.
    for (int i = 0; i < 600; i++) begin
      cpu_if.out_req  = ($urandom_range(0, 3) == 0);
      cpu_if.out_data = 8'($urandom);
      cpu_if.in_req   = ($urandom_range(0, 2) == 0);
      rx_ready        = ($urandom_range(0, 2) == 0);
      rx_ferr         = ($urandom_range(0, 7) == 0);
      rx_data         = 8'($urandom);
      tick();
    end
    cpu_if.out_req = 1'b0;
    cpu_if.in_req  = 1'b0;
    rx_ready       = 1'b0;
    rx_ferr        = 1'b0;
    wait_tx_drain(800);
    drain_rx();

    // Reset while waiting for uart_tx to accept, with three bytes still queued.
    mute_uart = 1;
    s0 = starts;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom), 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_tx_start", tx_start, 1'b0);
    chk("t5_out_ready", cpu_if.out_ready, 1'b1);
    chk("t5_in_valid", cpu_if.in_valid, 1'b0);
    chk("t5_tx_idle", tx_idle, 1'b1);
    mute_uart = 0;
    repeat (40) tick();
    chk("t5_no_more_starts", starts - s0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
